// File: rtl/ext_regbank.sv
// ext_regbank: self-contained register map (ID, W1C event flags, cycle counter, ctrl, RW bank)
// behind a simple clk/addr/din/dout/we bus with one-cycle registered reads.
module ext_regbank #(
    parameter int unsigned aw      = 4,
    parameter int unsigned dw      = 8,
    parameter int unsigned n_rw    = 4,
    parameter int unsigned RW_INIT = 'h40,
    parameter int unsigned ID      = 'haf
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [aw-1:0]       addr,
    input  logic [dw-1:0]       din,
    output logic [dw-1:0]       dout,
    input  logic                we,
    input  logic [dw-1:0]       ev,
    output logic [n_rw*dw-1:0]  rw_out,
    output logic [n_rw-1:0]     wstb
);

    localparam logic [dw-1:0] RW_INIT_V = dw'(RW_INIT);
    localparam logic [dw-1:0] ID_V      = dw'(ID);
    localparam logic [aw-1:0] A_ID      = aw'(0);
    localparam logic [aw-1:0] A_FLAGS   = aw'(1);
    localparam logic [aw-1:0] A_CNT     = aw'(2);
    localparam logic [aw-1:0] A_CTRL    = aw'(3);

    logic [dw-1:0]   rw_q [n_rw];
    logic [dw-1:0]   rw_d [n_rw];
    logic [n_rw-1:0] wstb_q, wstb_d;
    logic [dw-1:0]   flags_q, flags_d;
    logic [dw-1:0]   cnt_q, cnt_d;
    logic            en_q, en_d;
    logic [dw-1:0]   dout_q, dout_d;
    logic            sel_flags, sel_ctrl, clr;

    // Read mux samples pre-write state, so read-during-write returns the old value.
    always_comb begin
        dout_d = '0;
        case (addr)
            A_ID:    dout_d = ID_V;
            A_FLAGS: dout_d = flags_q;
            A_CNT:   dout_d = cnt_q;
            A_CTRL:  dout_d[0] = en_q;
            default: begin
                for (int unsigned k = 0; k < n_rw; k++) begin
                    if (addr == aw'(4 + k)) dout_d = rw_q[k];
                end
            end
        endcase
    end

    always_comb begin
        sel_flags = we && (addr == A_FLAGS);
        sel_ctrl  = we && (addr == A_CTRL);
        clr       = sel_ctrl && din[1];

        // Set wins over a simultaneous W1C clear.
        flags_d = (flags_q & ~(sel_flags ? din : '0)) | ev;

        if (clr)       cnt_d = '0;
        else if (en_q) cnt_d = cnt_q + dw'(1);
        else           cnt_d = cnt_q;

        en_d = sel_ctrl ? din[0] : en_q;

        rw_d   = rw_q;
        wstb_d = '0;
        for (int unsigned k = 0; k < n_rw; k++) begin
            if (we && (addr == aw'(4 + k))) begin
                rw_d[k]   = din;
                wstb_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < n_rw; k++) rw_q[k] <= RW_INIT_V;
            wstb_q  <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
            en_q    <= 1'b1;
            dout_q  <= '0;
        end else begin
            rw_q    <= rw_d;
            wstb_q  <= wstb_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        rw_out = '0;
        for (int unsigned k = 0; k < n_rw; k++) rw_out[k*dw +: dw] = rw_q[k];
    end

    assign dout = dout_q;
    assign wstb = wstb_q;

endmodule

// File: tb/tb_ext_regbank.sv
// Bench for ext_regbank: directed literal checks plus randomized traffic against a
// register-map reference model evaluated every cycle.
module tb_ext_regbank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  addr = '0;
    logic [7:0]  din = '0;
    logic [7:0]  dout;
    logic        we = 1'b0;
    logic [7:0]  ev = '0;
    logic [31:0] rw_out;
    logic [3:0]  wstb;

    int n_checks = 0;
    int n_errors = 0;

    ext_regbank #(
        .aw(4), .dw(8), .n_rw(4), .RW_INIT('h40), .ID('haf)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .din(din), .dout(dout),
        .we(we), .ev(ev), .rw_out(rw_out), .wstb(wstb)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the register map as plain arrays, advanced once per rising edge.
    int m_rw [4];
    int m_flags, m_cnt, m_en, m_dout, m_wstb;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_rw[k] = 'h40;
        m_flags = 0; m_cnt = 0; m_en = 1; m_dout = 0; m_wstb = 0;
    endtask

    function automatic int model_read(input int a);
        if (a == 0) return 'haf;
        if (a == 1) return m_flags;
        if (a == 2) return m_cnt;
        if (a == 3) return m_en;
        if (a >= 4 && a < 8) return m_rw[a-4];
        return 0;
    endfunction

    task automatic compare_loop();
        int a, d, w, e, exp_rw;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                a = int'(addr); d = int'(din); w = int'(we); e = int'(ev);
                m_dout = model_read(a);
                m_wstb = 0;
                if (w == 1 && a >= 4 && a < 8) begin
                    m_rw[a-4] = d;
                    m_wstb = 1 << (a - 4);
                end
                m_flags = (m_flags & ~((w == 1 && a == 1) ? d : 0) | e) & 'hff;
                if (w == 1 && a == 3 && (d & 2) != 0) m_cnt = 0;
                else if (m_en == 1) m_cnt = (m_cnt + 1) % 256;
                if (w == 1 && a == 3) m_en = d & 1;
            end
            #1;
            exp_rw = m_rw[0] + (m_rw[1] << 8) + (m_rw[2] << 16) + (m_rw[3] << 24);
            chk("model_dout", 32'(dout), 32'(m_dout));
            chk("model_rw_out", rw_out, 32'(exp_rw));
            chk("model_wstb", 32'(wstb), 32'(m_wstb));
        end
    endtask

    task automatic drive(input int a, input int d, input int w, input int e);
        @(negedge clk);
        addr = 4'(a); din = 8'(d); we = w[0]; ev = 8'(e);
        @(posedge clk);
        #2;
    endtask

    task automatic main_seq();
        // reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_rw_out", rw_out, 32'h40404040);
        chk("reset_wstb", 32'(wstb), 32'h0);
        chk("reset_dout", 32'(dout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(0, 0, 0, 0);
        chk("read_id", 32'(dout), 32'haf);
        for (int a = 4; a < 8; a++) begin
            drive(a, 0, 0, 0);
            chk("read_rw_init", 32'(dout), 32'h40);
        end

        // RW write, strobe, read-during-write
        drive(5, 'h5a, 1, 0);
        chk("wr5_dout_old", 32'(dout), 32'h40);
        chk("wr5_wstb", 32'(wstb), 32'b0010);
        chk("wr5_rw_out", rw_out, 32'h40405a40);
        drive(5, 0, 0, 0);
        chk("wr5_wstb_once", 32'(wstb), 32'h0);
        chk("rd5", 32'(dout), 32'h5a);
        drive(5, 'h11, 1, 0);
        chk("rdw_old", 32'(dout), 32'h5a);
        drive(5, 0, 0, 0);
        chk("rdw_new", 32'(dout), 32'h11);

        // flags
        drive(1, 0, 0, 3);
        chk("flags_before", 32'(dout), 32'h0);
        drive(1, 0, 0, 0);
        chk("flags_set", 32'(dout), 32'h03);
        drive(1, 1, 1, 0);
        drive(1, 0, 0, 0);
        chk("flags_w1c", 32'(dout), 32'h02);
        drive(1, 2, 1, 2);
        drive(1, 0, 0, 0);
        chk("flags_set_wins", 32'(dout), 32'h02);
        drive(1, 2, 1, 0);
        drive(1, 0, 0, 0);
        chk("flags_cleared", 32'(dout), 32'h00);

        // counter: clear, run to wrap, hold, clear again
        drive(3, 3, 1, 0);
        chk("ctrl_read_en", 32'(dout), 32'h01);
        drive(2, 0, 0, 0);
        chk("cnt_after_clr", 32'(dout), 32'h00);
        drive(2, 0, 0, 0);
        chk("cnt_inc", 32'(dout), 32'h01);
        repeat (254) drive(2, 0, 0, 0);
        chk("cnt_ff", 32'(dout), 32'hff);
        drive(2, 0, 0, 0);
        chk("cnt_wrap", 32'(dout), 32'h00);
        drive(3, 0, 1, 0);
        drive(2, 0, 0, 0);
        chk("cnt_hold_a", 32'(dout), 32'h02);
        drive(2, 0, 0, 0);
        chk("cnt_hold_b", 32'(dout), 32'h02);
        drive(3, 0, 0, 0);
        chk("ctrl_read_dis", 32'(dout), 32'h00);
        drive(3, 3, 1, 0);
        drive(3, 0, 0, 0);
        chk("ctrl_read_01", 32'(dout), 32'h01);
        drive(2, 0, 0, 0);
        chk("cnt_restart", 32'(dout), 32'h01);
        drive(2, 0, 0, 0);
        chk("cnt_restart_inc", 32'(dout), 32'h02);

        // unmapped address
        drive(12, 'hff, 1, 0);
        chk("unmapped_wr_dout", 32'(dout), 32'h0);
        chk("unmapped_rw_out", rw_out, 32'h40401140);
        chk("unmapped_wstb", 32'(wstb), 32'h0);
        drive(12, 0, 0, 0);
        chk("unmapped_rd", 32'(dout), 32'h0);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 15), $urandom_range(0, 255),
                  ($urandom_range(0, 2) == 0) ? 1 : 0,
                  ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : 0);
        end

        // reset asserted between edges while a write is pending
        drive(4, 'haa, 1, 0);
        drive(7, 0, 0, 0);
        @(negedge clk);
        addr = 4'd6; din = 8'h77; we = 1'b1; ev = 8'h0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dout", 32'(dout), 32'h0);
        chk("async_rst_rw_out", rw_out, 32'h40404040);
        chk("async_rst_wstb", 32'(wstb), 32'h0);
        we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(6, 0, 0, 0);
        chk("post_rst_rd6", 32'(dout), 32'h40);
        drive(0, 0, 0, 0);
        chk("post_rst_id", 32'(dout), 32'haf);
    endtask

    initial begin
        model_reset();
        fork
            compare_loop();
            main_seq();
        join_any
        disable fork;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
